// File: rtl/uart_pkg.sv
// Shared UART timing constants: oversample factor and the reset divisor for a
// 50 MHz clock at 19200 baud.
package uart_pkg;

  // Rounded clock divisor for one oversample tick.
  function automatic int unsigned calc_div(int unsigned clk_hz, int unsigned baud,
                                           int unsigned os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

  localparam int unsigned OS_DEFAULT      = 16;
  localparam int unsigned DIV_50M_19200   = calc_div(50_000_000, 19200, OS_DEFAULT);
  localparam int unsigned DIV_RST_DEFAULT = DIV_50M_19200;

endpackage

// File: rtl/prog_mod_counter.sv
// Counter with runtime terminal value: counts 0..last, wraps to 0 and flags the
// wrap cycle combinationally.
module prog_mod_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_d, count_q;
  logic         hit;

  assign hit   = (count_q == last);
  // A reset or clear cycle never reports a wrap.
  assign wrap  = en & ~clr & ~reset & hit;
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = hit ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Programmable baud tick generator: cycle counter produces oversample ticks,
// oversample counter produces bit ticks; divisor updates land on period boundaries.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned N       = 16,
  parameter int unsigned OS      = OS_DEFAULT,
  parameter int unsigned DIV_RST = DIV_RST_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  div_wr,
  input  logic [N-1:0]          div_in,
  output logic                  s_tick,
  output logic                  b_tick,
  output logic [N-1:0]          q,
  output logic [$clog2(OS)-1:0] os_q,
  output logic [N-1:0]          div_cur,
  output logic                  div_pend
);

  localparam int unsigned          OSW     = $clog2(OS);
  localparam logic [OSW-1:0]       OS_LAST = OSW'(OS - 1);

  logic [N-1:0] div_cur_d, div_cur_q;
  logic [N-1:0] pend_val_d, pend_val_q;
  logic         pend_d, pend_q;
  logic [N-1:0] new_div;
  logic         wr_ok, apply, clamp;

  assign wr_ok = div_wr & (div_in != '0);
  assign apply = s_tick | clr | ~en;

  // A same-cycle write bypasses the pending register.
  assign new_div = wr_ok ? div_in : (pend_q ? pend_val_q : div_cur_q);

  // Shrinking the divisor while idle must not leave q beyond the new terminal value.
  assign clamp = ~en & (q >= new_div);

  always_comb begin
    div_cur_d  = div_cur_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    if (apply) begin
      div_cur_d = new_div;
      pend_d    = 1'b0;
    end else if (wr_ok) begin
      pend_val_d = div_in;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cur_q  <= N'(DIV_RST);
      pend_val_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      div_cur_q  <= div_cur_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
    end
  end

  prog_mod_counter #(
    .W(N)
  ) u_cycle_cnt (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (clr | clamp),
    .last (div_cur_q - 1'b1),
    .count(q),
    .wrap (s_tick)
  );

  prog_mod_counter #(
    .W(OSW)
  ) u_os_cnt (
    .clk  (clk),
    .reset(reset),
    .en   (s_tick),
    .clr  (clr),
    .last (OS_LAST),
    .count(os_q),
    .wrap (b_tick)
  );

  assign div_cur  = div_cur_q;
  assign div_pend = pend_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: expected s_tick events are queued by the
// stimulus and matched by an independent monitor.
module tb_baud_tick_gen;

  localparam int unsigned N       = 16;
  localparam int unsigned OS      = 16;
  localparam int unsigned DIV_RST = 163;

  logic         clk = 1'b0;
  logic         reset, en, clr, div_wr;
  logic [N-1:0] div_in;
  logic         s_tick, b_tick, div_pend;
  logic [N-1:0] q, div_cur;
  logic [3:0]   os_q;

  baud_tick_gen #(
    .N      (N),
    .OS     (OS),
    .DIV_RST(DIV_RST)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .clr     (clr),
    .div_wr  (div_wr),
    .div_in  (div_in),
    .s_tick  (s_tick),
    .b_tick  (b_tick),
    .q       (q),
    .os_q    (os_q),
    .div_cur (div_cur),
    .div_pend(div_pend)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           at;
    logic         b;
    logic [N-1:0] qv;
    logic [3:0]   os;
  } tick_t;

  tick_t exp_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  int    exp_os = 0;
  bit    done   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_tick(input int at, input int div);
    tick_t t;
    t.at   = at;
    t.b    = (exp_os == OS - 1);
    t.qv   = N'(div - 1);
    t.os   = 4'(exp_os);
    exp_q.push_back(t);
    exp_os = (exp_os + 1) % OS;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every s_tick must match the head of the expectation queue.
  always @(negedge clk) begin
    tick_t t;
    if (!done) begin
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        check("missed_s_tick", cyc, exp_q[0].at);
        void'(exp_q.pop_front());
      end
      if (s_tick) begin
        if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
          t = exp_q.pop_front();
          check("tick_q", q, t.qv);
          check("tick_os_q", os_q, t.os);
          check("tick_b_tick", b_tick, t.b);
        end else begin
          check("unexpected_s_tick", s_tick, 0);
        end
      end else if (b_tick) begin
        check("b_tick_without_s_tick", b_tick, 0);
      end
    end
  end

  initial begin
    int t0, c, y, r;
    reset  = 1'b1;
    en     = 1'b0;
    clr    = 1'b0;
    div_wr = 1'b0;
    div_in = '0;
    step();
    check("reset_q", q, 0);
    check("reset_os_q", os_q, 0);
    check("reset_div_cur", div_cur, DIV_RST);
    check("reset_div_pend", div_pend, 0);

    // Free run at the reset divisor.
    reset = 1'b0;
    en    = 1'b1;
    t0    = cyc;
    exp_os = 0;
    for (int i = 0; i < 30; i++) push_tick(t0 + 162 + 163 * i, 163);
    for (int k = 1; k < 5000; k++) step();

    // Clear, then deferred write of 10 at q=50 (plus an ignored zero write).
    clr = 1'b1;
    step();
    clr    = 1'b0;
    c      = cyc;
    exp_os = 0;
    push_tick(c + 162, 163);
    for (int i = 0; i < 6; i++) push_tick(c + 172 + 10 * i, 10);
    for (int i = 0; i < 9; i++) push_tick(c + 226 + 4 * i, 4);
    for (int k = 0; k < 262; k++) begin
      if (k == 0) begin
        check("clr_q", q, 0);
        check("clr_os_q", os_q, 0);
      end
      if (k == 51) begin
        check("pend_set", div_pend, 1);
        check("pend_div_cur_held", div_cur, 163);
      end
      if (k == 61) check("zero_write_pend_kept", div_pend, 1);
      if (k == 163) begin
        check("apply_div_cur", div_cur, 10);
        check("apply_pend_clr", div_pend, 0);
        check("apply_q_wrap", q, 0);
      end
      if (k == 223) begin
        check("bypass_div_cur", div_cur, 4);
        check("bypass_pend", div_pend, 0);
      end
      div_wr = (k == 50) || (k == 60) || (k == 222);
      div_in = (k == 50) ? N'(10) : (k == 222) ? N'(4) : '0;
      step();
    end
    div_wr = 1'b0;

    // Clear on a would-be tick cycle, zero write, then divisor 1 while idle.
    clr = 1'b1;
    step();
    y      = cyc;
    clr    = 1'b0;
    en     = 1'b0;
    div_wr = 1'b1;
    div_in = '0;
    exp_os = 0;
    step();
    check("zero_write_div_cur", div_cur, 4);
    check("zero_write_pend", div_pend, 0);
    div_in = N'(1);
    step();
    check("idle_apply_div_cur", div_cur, 1);
    check("idle_apply_pend", div_pend, 0);
    div_wr = 1'b0;
    en     = 1'b1;
    for (int i = 0; i < 40; i++) push_tick(y + 2 + i, 1);
    for (int i = 0; i < 40; i++) step();
    en = 1'b0;

    // Back to 163, clear at q=80/os_q=7, then an idle hold.
    div_wr = 1'b1;
    div_in = N'(163);
    step();
    check("restore_div_cur", div_cur, 163);
    div_wr = 1'b0;
    clr    = 1'b1;
    en     = 1'b1;
    step();
    clr    = 1'b0;
    c      = cyc;
    exp_os = 0;
    for (int i = 0; i < 7; i++) push_tick(c + 162 + 163 * i, 163);
    for (int k = 0; k < 1221; k++) step();
    check("pre_clr_q", q, 80);
    check("pre_clr_os_q", os_q, 7);
    clr = 1'b1;
    step();
    check("mid_clr_q", q, 0);
    check("mid_clr_os_q", os_q, 0);
    clr    = 1'b0;
    exp_os = 0;
    for (int k = 0; k < 30; k++) step();
    en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      check("hold_q", q, 30);
    end
    en = 1'b1;
    for (int k = 0; k < 132; k++) step();
    check("clr_tick_q", q, 162);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_tick_after_q", q, 0);

    // Reset with a pending divisor at q=100.
    c = cyc;
    for (int k = 0; k < 100; k++) begin
      div_wr = (k == 50);
      div_in = (k == 50) ? N'(10) : '0;
      step();
      if (k == 50) check("rst_pend_set", div_pend, 1);
    end
    div_wr = 1'b0;
    check("rst_pre_q", q, 100);
    reset = 1'b1;
    step();
    check("rst_q", q, 0);
    check("rst_os_q", os_q, 0);
    check("rst_div_cur", div_cur, DIV_RST);
    check("rst_pend", div_pend, 0);
    reset  = 1'b0;
    r      = cyc;
    exp_os = 0;
    push_tick(r + 162, 163);
    for (int k = 0; k < 325; k++) step();
    check("rst_tick_q", q, 162);
    reset = 1'b1;
    step();
    reset = 1'b0;
    en    = 1'b0;
    check("rst_tick_after_q", q, 0);
    check("rst_tick_after_os_q", os_q, 0);
    step();
    step();
    done = 1'b1;
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
- REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high, with ports named clk and reset.
- REQ-002 The block SHALL have parameter N, default 16: width of divisor and cycle counter.
- REQ-003 The block SHALL have parameter OS, default 16: oversample factor (s_ticks per b_tick), >= 2.
- REQ-004 The block SHALL have parameter DIV_RST, default 163: divisor loaded at reset, 1 <= DIV_RST < 2^N.
- REQ-005 The block SHALL have port clk, input, width 1: rising-edge clock.
- REQ-006 The block SHALL have port reset, input, width 1: synchronous active-high reset.
- REQ-007 The block SHALL have port en, input, width 1: counting enable.
- REQ-008 The block SHALL have port clr, input, width 1: synchronous clear of both counters.
- REQ-009 The block SHALL have port div_wr, input, width 1: single-cycle divisor write strobe.
- REQ-010 The block SHALL have port div_in, input, width N: new divisor value.
- REQ-011 The block SHALL have port s_tick, output, width 1: oversample tick, one cycle wide.
- REQ-012 The block SHALL have port b_tick, output, width 1: bit tick, one cycle wide.
- REQ-013 The block SHALL have port q, output, width N: cycle-counter value.
- REQ-014 The block SHALL have port os_q, output, width $clog2(OS): oversample-counter value.
- REQ-015 The block SHALL have port div_cur, output, width N: active divisor.
- REQ-016 The block SHALL have port div_pend, output, width 1: a divisor write is pending.

Function
- REQ-017 When en=1 and clr=0, q SHALL count 0..div_cur-1 and wrap to 0.
- REQ-018 s_tick SHALL be combinational: en & ~clr & (q == div_cur-1).
- REQ-019 os_q SHALL increment only on s_tick cycles and wrap from OS-1 to 0.
- REQ-020 b_tick SHALL equal s_tick & (os_q == OS-1); s_tick SHALL therefore be exactly OS times as frequent as b_tick.
- REQ-021 With en=0, q and os_q SHALL hold and s_tick and b_tick SHALL be 0.
- REQ-022 clr=1 SHALL set q and os_q to 0 on the next edge, regardless of en; no tick SHALL occur in a clr cycle.
- REQ-023 div_wr=1 with div_in != 0 SHALL load div_in into a pending register and set div_pend.
- REQ-024 div_wr=1 with div_in == 0 SHALL be ignored; the pending register and div_pend SHALL be unchanged.
- REQ-025 A pending divisor SHALL become div_cur at the first edge satisfying any of: s_tick=1, clr=1, or en=0. div_pend SHALL clear on that same edge.
- REQ-026 Divisor changes SHALL never truncate a period in progress.
- REQ-027 A div_wr coinciding with a REQ-025 apply condition SHALL take effect on that same edge (bypass): div_cur=div_in, div_pend=0.
- REQ-028 A second div_wr before apply SHALL overwrite the pending value; last write wins.
- REQ-029 div_cur=1 SHALL produce s_tick on every enabled, non-clr cycle with q constant at 0.
- REQ-030 q SHALL never exceed div_cur-1.
- REQ-031 Counter arithmetic SHALL be modulo-free: explicit compare-and-reset, no reliance on N-bit overflow.

Reset
- REQ-032 reset SHALL have priority over clr, en and div_wr.
- REQ-033 On reset, q, os_q, div_pend, s_tick and b_tick SHALL all go to 0, div_cur SHALL become DIV_RST, and any pending divisor SHALL be discarded.
- REQ-034 Reset asserted mid-period SHALL take effect at the next edge with no tick emitted.

Structure
- REQ-035 Package uart_pkg SHALL hold DIV_RST default, OS default, and the 50 MHz/19200-baud divisor constant.
- REQ-036 The block SHALL use one sub-module, prog_mod_counter (runtime modulus, enable, clear, wrap tick), instantiated twice: cycle counter (modulus div_cur) and oversample counter (modulus OS).
- REQ-037 Divisor/pending logic SHALL reside in baud_tick_gen.

Verification
- REQ-038 Reset, N=16, OS=16, DIV_RST=163, en=1 for 5000 cycles -> first s_tick at cycle 163 (q=162), s_tick every 163 cycles, b_tick every 2608 cycles.
- REQ-039 div_wr with div_in=10 at q=50 -> div_pend=1; current period completes at 163; next periods last 10 cycles; div_pend=0 after the wrap.
- REQ-040 div_wr on the same cycle as s_tick with div_in=4 -> div_cur=4 next cycle, div_pend stays 0.
- REQ-041 div_in=0 write -> no change; then div_in=1 with en=0 -> applied next edge, and after en=1 s_tick is high every cycle, b_tick every 16.
- REQ-042 clr at q=80, os_q=7 -> q=0, os_q=0 next cycle, no tick; en=0 for 20 cycles -> q frozen and no ticks.
- REQ-043 reset asserted with div_pend=1 and q=100 -> all outputs 0, div_cur=163, pending discarded, no tick in the reset cycle.
